// File: rtl/taxi_apb_pkg.sv
// Shared types for the APB arbiter: FSM state encoding and the grant-index width helper.
package taxi_apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } arb_state_t;

    function automatic int unsigned cl_ports(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/taxi_apb_if.sv
// APB bus bundle with a manager view (mst) and a completer view (slv).
interface taxi_apb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] paddr;
    logic [2:0]        pprot;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport mst (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slv (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/taxi_apb_arb_rr.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module taxi_apb_arb_rr import taxi_apb_pkg::*; #(
    parameter int unsigned PORTS = 4,
    localparam int unsigned CL_PORTS = cl_ports(PORTS)
) (
    input  logic [PORTS-1:0]    req,
    input  logic [CL_PORTS-1:0] ptr,
    output logic                valid,
    output logic [CL_PORTS-1:0] idx
);
    logic [CL_PORTS-1:0] cand;

    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = '0;
        // Scan farthest to nearest so the nearest requester after ptr overwrites last.
        for (int k = int'(PORTS); k > 0; k--) begin
            cand = CL_PORTS'((int'(ptr) + k) % PORTS);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/taxi_apb_arb.sv
// N-to-1 APB arbiter: round-robin grant, downstream SETUP/ACCESS replay, one-cycle response.
// Defining TAXI_APB_ARB_TIMEOUT_EN adds an ACCESS-phase timeout of TIMEOUT_CYCLES.
module taxi_apb_arb import taxi_apb_pkg::*; #(
    parameter int unsigned PORTS          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned CL_PORTS      = cl_ports(PORTS)
) (
    input  logic                clk,
    input  logic                rst,
    taxi_apb_if.slv             s_apb [PORTS],
    taxi_apb_if.mst             m_apb,
    output logic                busy,
    output logic [CL_PORTS-1:0] gnt_idx
);
    localparam int unsigned DATA_W = $bits(m_apb.pwdata);
    localparam int unsigned ADDR_W = $bits(m_apb.paddr);
    localparam int unsigned STRB_W = $bits(m_apb.pstrb);

    logic [PORTS-1:0]  req;
    logic [PORTS-1:0]  penable_in;
    logic [ADDR_W-1:0] paddr_in  [PORTS];
    logic [2:0]        pprot_in  [PORTS];
    logic [PORTS-1:0]  pwrite_in;
    logic [DATA_W-1:0] pwdata_in [PORTS];
    logic [STRB_W-1:0] pstrb_in  [PORTS];

    arb_state_t          state_q;
    logic [CL_PORTS-1:0] ptr_q;
    logic [CL_PORTS-1:0] gnt_q;
    logic                rr_valid;
    logic [CL_PORTS-1:0] rr_idx;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [2:0]          pprot_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [PORTS-1:0]    pready_q;
    logic [DATA_W-1:0]   prdata_q;
    logic                pslverr_q;
    logic                tmo_hit;

    for (genvar g = 0; g < PORTS; g++) begin : g_port
        if ($bits(s_apb[g].pwdata) != DATA_W || $bits(s_apb[g].paddr) != ADDR_W ||
            $bits(s_apb[g].pstrb) != STRB_W) begin : g_width_err
            $fatal(1, "taxi_apb_arb: s_apb[%0d] width does not match m_apb", g);
        end
        assign req[g]        = s_apb[g].psel;
        assign penable_in[g] = s_apb[g].penable;
        assign paddr_in[g]   = s_apb[g].paddr;
        assign pprot_in[g]   = s_apb[g].pprot;
        assign pwrite_in[g]  = s_apb[g].pwrite;
        assign pwdata_in[g]  = s_apb[g].pwdata;
        assign pstrb_in[g]   = s_apb[g].pstrb;
        // Response data is shared; only the pulsed port sees non-zero values.
        assign s_apb[g].pready  = pready_q[g];
        assign s_apb[g].prdata  = pready_q[g] ? prdata_q : '0;
        assign s_apb[g].pslverr = pready_q[g] & pslverr_q;
    end

    // Upstream penable carries no information for granting.
    logic unused_penable;
    assign unused_penable = ^penable_in;

    taxi_apb_arb_rr #(
        .PORTS(PORTS)
    ) u_rr (
        .req  (req),
        .ptr  (ptr_q),
        .valid(rr_valid),
        .idx  (rr_idx)
    );

`ifdef TAXI_APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != StAccess) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end
    assign tmo_hit = (state_q == StAccess) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= CL_PORTS'(PORTS - 1);
            gnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pready_q  <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rr_valid) begin
                        paddr_q  <= paddr_in[rr_idx];
                        pprot_q  <= pprot_in[rr_idx];
                        pwrite_q <= pwrite_in[rr_idx];
                        pwdata_q <= pwdata_in[rr_idx];
                        pstrb_q  <= pstrb_in[rr_idx];
                        gnt_q    <= rr_idx;
                        ptr_q    <= rr_idx;
                        psel_q   <= 1'b1;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (m_apb.pready || tmo_hit) begin
                        psel_q          <= 1'b0;
                        penable_q       <= 1'b0;
                        prdata_q        <= m_apb.pready ? m_apb.prdata : '0;
                        pslverr_q       <= m_apb.pready ? m_apb.pslverr : 1'b1;
                        pready_q[gnt_q] <= 1'b1;
                        state_q         <= StResp;
                    end
                end
                StResp: begin
                    pready_q  <= '0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_apb.psel    = psel_q;
    assign m_apb.penable = penable_q;
    assign m_apb.pwrite  = pwrite_q;
    assign m_apb.paddr   = paddr_q;
    assign m_apb.pprot   = pprot_q;
    assign m_apb.pwdata  = pwdata_q;
    assign m_apb.pstrb   = pstrb_q;
    assign busy          = (state_q != StIdle);
    assign gnt_idx       = gnt_q;
endmodule

// File: tb/tb_taxi_apb_arb.sv
// Randomised scoreboard bench for taxi_apb_arb with directed latency/contention/reset cases.
module tb_taxi_apb_arb;
    localparam int P = 4;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic [1:0] gnt_idx;
    always #5 clk = ~clk;

    taxi_apb_if #(.DATA_W(32), .ADDR_W(32), .STRB_W(4)) s_apb [P] ();
    taxi_apb_if #(.DATA_W(32), .ADDR_W(32), .STRB_W(4)) m_apb ();

    taxi_apb_arb #(
        .PORTS         (P),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_apb  (s_apb),
        .m_apb  (m_apb),
        .busy   (busy),
        .gnt_idx(gnt_idx)
    );

    // Manager-side stimulus state
    logic [P-1:0] act = '0;
    logic [P-1:0] a_pen = '0;
    logic [P-1:0] a_wr = '0;
    logic [31:0]  a_addr [P];
    logic [31:0]  a_wdata [P];
    logic [3:0]   a_strb [P];
    logic [2:0]   a_prot [P];
    logic [P-1:0] s_pready;
    logic [31:0]  s_prdata [P];
    logic [P-1:0] s_pslverr;

    // Directed request mailbox (main writes seq, manager process writes done)
    int          dir_seq [P];
    int          dir_done [P];
    logic        d_wr [P];
    logic [31:0] d_addr [P];
    logic [31:0] d_wdata [P];
    logic [3:0]  d_strb [P];
    logic        rand_en = 1'b0;
    logic        hold_en = 1'b0;

    // Completer model
    logic        c_pready = 1'b0;
    logic [31:0] c_prdata = '0;
    logic        c_pslverr = 1'b0;
    int          c_seq = 0;
    int          c_done = 0;
    int          c_cnt = 0;
    logic        c_loaded = 1'b0;
    int          c_wait = 0;
    logic [31:0] c_data = '0;
    logic        c_err = 1'b0;
    int          wait_cfg = -1;
    logic        fix_en = 1'b0;
    logic [31:0] fix_data = '0;
    logic        fix_err = 1'b0;
    logic        hang = 1'b0;

    // Scoreboard / reference state
    exp_t         exp_q [$];
    int           grant_log [$];
    logic [P-1:0] seen = '0;
    logic [P-1:0] prev_req = '0;
    int           ptr_m = P - 1;
    int           cur_w = -1;
    int           nvec = 0;
    int           nerr = 0;

    for (genvar g = 0; g < P; g++) begin : g_bind
        assign s_apb[g].psel    = act[g];
        assign s_apb[g].penable = a_pen[g];
        assign s_apb[g].pwrite  = a_wr[g];
        assign s_apb[g].paddr   = a_addr[g];
        assign s_apb[g].pwdata  = a_wdata[g];
        assign s_apb[g].pstrb   = a_strb[g];
        assign s_apb[g].pprot   = a_prot[g];
        assign s_pready[g]      = s_apb[g].pready;
        assign s_prdata[g]      = s_apb[g].prdata;
        assign s_pslverr[g]     = s_apb[g].pslverr;
    end
    assign m_apb.pready  = c_pready;
    assign m_apb.prdata  = c_prdata;
    assign m_apb.pslverr = c_pslverr;

    initial begin
        for (int i = 0; i < P; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0; a_strb[i] = '0; a_prot[i] = '0;
            dir_seq[i] = 0; dir_done[i] = 0;
            d_wr[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0; d_strb[i] = '0;
        end
    end

    // Upstream managers: hold a request until its pready is seen, then maybe start another.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < P; i++) begin
            if (rst) begin
                act[i] = 1'b0;
                a_pen[i] = 1'b0;
            end else begin
                if (act[i] && seen[i]) begin
                    act[i] = 1'b0;
                    a_pen[i] = 1'b0;
                end else if (act[i]) begin
                    a_pen[i] = 1'b1;
                end
                if (!act[i]) begin
                    if (dir_done[i] != dir_seq[i]) begin
                        a_wr[i] = d_wr[i]; a_addr[i] = d_addr[i];
                        a_wdata[i] = d_wdata[i]; a_strb[i] = d_strb[i];
                        a_prot[i] = 3'($urandom_range(0, 7));
                        dir_done[i] = dir_seq[i];
                        act[i] = 1'b1;
                    end else if (hold_en || (rand_en && $urandom_range(0, 3) == 0)) begin
                        a_wr[i] = 1'($urandom_range(0, 1));
                        a_addr[i] = $urandom & 32'h0000_FFFC;
                        a_wdata[i] = $urandom;
                        a_strb[i] = a_wr[i] ? 4'($urandom_range(0, 15)) : 4'h0;
                        a_prot[i] = 3'($urandom_range(0, 7));
                        act[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Downstream completer: answers each announced transfer after c_wait wait states.
    always @(posedge clk) begin
        #1;
        c_pready = 1'b0;
        c_prdata = $urandom;
        c_pslverr = 1'($urandom_range(0, 1));
        if (rst) begin
            c_done = c_seq;
            c_loaded = 1'b0;
        end else if (c_done != c_seq) begin
            if (!c_loaded) begin
                c_cnt = c_wait;
                c_loaded = 1'b1;
            end
            if (c_cnt == 0) begin
                c_pready = 1'b1;
                c_prdata = c_data;
                c_pslverr = c_err;
                c_done = c_seq;
                c_loaded = 1'b0;
            end else begin
                c_cnt--;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        nvec++;
        if (act_v !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    function automatic int rr_pick(input logic [P-1:0] req, input int ptr);
        for (int k = 1; k <= P; k++) begin
            if (req[(ptr + k) % P]) return (ptr + k) % P;
        end
        return -1;
    endfunction

    task automatic chk_fields(input string tag, input int w);
        chk({tag, "_addr"}, m_apb.paddr, a_addr[w]);
        chk({tag, "_write"}, m_apb.pwrite, a_wr[w]);
        chk({tag, "_wdata"}, m_apb.pwdata, a_wdata[w]);
        chk({tag, "_strb"}, m_apb.pstrb, a_strb[w]);
        chk({tag, "_prot"}, m_apb.pprot, a_prot[w]);
    endtask

    task automatic monitor();
        int   w;
        logic bad;
        exp_t e;
        seen = s_pready;
        if (rst) begin
            exp_q.delete();
            ptr_m = P - 1;
            cur_w = -1;
            prev_req = '0;
            return;
        end
        if (s_pready != '0) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", s_pready, 0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_port", s_pready, 64'(1) << e.port);
                chk("resp_data", s_prdata[e.port], e.data);
                chk("resp_err", s_pslverr[e.port], e.err);
            end
        end
        bad = 1'b0;
        for (int i = 0; i < P; i++) begin
            if (!s_pready[i] && (s_prdata[i] != 0 || s_pslverr[i])) bad = 1'b1;
        end
        chk("isolation", bad, 0);
        if (m_apb.psel && !m_apb.penable) begin
            w = rr_pick(prev_req, ptr_m);
            chk("grant_valid", w >= 0, 1);
            if (w >= 0) begin
                chk("gnt_idx", gnt_idx, w);
                chk_fields("setup", w);
                grant_log.push_back(int'(gnt_idx));
                ptr_m = w;
                cur_w = w;
                if (!hang) begin
                    c_wait = (wait_cfg >= 0) ? wait_cfg : $urandom_range(0, 3);
                    c_data = fix_en ? fix_data : $urandom;
                    c_err = fix_en ? fix_err : 1'($urandom_range(0, 1));
                    c_seq++;
                    e.port = w; e.data = c_data; e.err = c_err;
                    exp_q.push_back(e);
                end else begin
`ifdef TAXI_APB_ARB_TIMEOUT_EN
                    e.port = w; e.data = '0; e.err = 1'b1;
                    exp_q.push_back(e);
`endif
                end
            end
        end else if (m_apb.psel && m_apb.penable && cur_w >= 0) begin
            chk_fields("access", cur_w);
        end
        prev_req = act;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic issue(input int p, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        d_wr[p] = wr; d_addr[p] = addr; d_wdata[p] = data; d_strb[p] = strb;
        dir_seq[p]++;
    endtask

    task automatic wait_grants(input int base, input int n, input int budget);
        for (int i = 0; i < budget && grant_log.size() < base + n; i++) tick();
        chk("grant_wait", grant_log.size() >= base + n, 1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (act != '0 || busy || exp_q.size() != 0); i++) tick();
        chk("drain", {act != '0, busy, exp_q.size() != 0}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        int ord [8];
        logic bad;

        // Reset state
        repeat (3) tick();
        chk("rst_psel", m_apb.psel, 0);
        chk("rst_penable", m_apb.penable, 0);
        chk("rst_fields", {m_apb.pwrite, m_apb.paddr, m_apb.pwdata, m_apb.pstrb, m_apb.pprot}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_idx, 0);
        bad = 1'b0;
        for (int i = 0; i < P; i++) if (s_prdata[i] != 0 || s_pslverr[i]) bad = 1'b1;
        chk("rst_upstream", {s_pready, bad}, 0);
        rst = 1'b0;
        tick();

        // Single zero-wait write on port 1
        wait_cfg = 0;
        issue(1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
        tick();
        chk("wr_n_psel", m_apb.psel, 0);
        tick();
        chk("wr_n1_setup", {m_apb.psel, m_apb.penable, busy}, 3'b101);
        chk("wr_n1_gnt", gnt_idx, 1);
        tick();
        chk("wr_n2_access", {m_apb.psel, m_apb.penable}, 2'b11);
        tick();
        chk("wr_n3_pready", s_pready, 4'b0010);
        chk("wr_n3_gnt", gnt_idx, 1);
        tick();
        chk("wr_n4_idle", {busy, m_apb.psel, s_pready}, 0);

        // Read with three wait states and an error response on port 0
        wait_cfg = 3;
        fix_en = 1'b1; fix_data = 32'h1234_5678; fix_err = 1'b1;
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        repeat (5) tick();
        chk("rd_n5_wait", s_pready, 0);
        tick();
        chk("rd_n6_pready", s_pready, 4'b0001);
        chk("rd_n6_data", s_prdata[0], 32'h1234_5678);
        chk("rd_n6_err", s_pslverr[0], 1);
        fix_en = 1'b0;
        wait_cfg = -1;
        drain(20);

        // Contention from reset: 0,2,3 together, then all four continuously
        do_reset();
        base = grant_log.size();
        issue(0, 1'b1, 32'h100, 32'h1, 4'h1);
        issue(2, 1'b1, 32'h200, 32'h2, 4'h3);
        issue(3, 1'b0, 32'h300, 32'h0, 4'h0);
        wait_grants(base, 3, 60);
        ord[0] = 0; ord[1] = 2; ord[2] = 3;
        for (int k = 0; k < 3; k++) begin
            if (grant_log.size() > base + k) chk("order_023", grant_log[base + k], ord[k]);
        end
        base = grant_log.size();
        hold_en = 1'b1;
        wait_grants(base, 8, 120);
        hold_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ord[k] = k % P;
            if (grant_log.size() > base + k) chk("order_rr", grant_log[base + k], ord[k]);
        end
        drain(60);

        // Reset in the middle of ACCESS abandons the transfer and rewinds the pointer
        hang = 1'b1;
        issue(1, 1'b1, 32'h44, 32'h5555_AAAA, 4'hF);
        tick();
        tick();
        tick();
        chk("rst_mid_access", {m_apb.psel, m_apb.penable}, 2'b11);
        rst = 1'b1;
        tick();
        chk("rst_mid_psel", m_apb.psel, 0);
        chk("rst_mid_no_resp", s_pready, 0);
        rst = 1'b0;
        hang = 1'b0;
        tick();
        tick();
        base = grant_log.size();
        issue(0, 1'b0, 32'h8, 32'h0, 4'h0);
        issue(2, 1'b0, 32'hC, 32'h0, 4'h0);
        wait_grants(base, 1, 20);
        if (grant_log.size() > base) chk("rst_next_grant", grant_log[base], 0);
        drain(40);

        // Completer that never answers
        hang = 1'b1;
        issue(2, 1'b1, 32'h80, 32'hCAFE_F00D, 4'hF);
        tick();
`ifdef TAXI_APB_ARB_TIMEOUT_EN
        repeat (9) tick();
        chk("tmo_n9_wait", s_pready, 0);
        tick();
        chk("tmo_n10_pready", s_pready, 4'b0100);
        chk("tmo_n10_resp", {s_prdata[2], s_pslverr[2]}, 33'h1);
        tick();
        hang = 1'b0;
        drain(20);
`else
        repeat (100) tick();
        chk("no_tmo_waiting", {m_apb.psel, m_apb.penable, s_pready}, 6'b110000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hang = 1'b0;
        tick();
`endif

        // Isolation: others hold psel through a port 2 transfer
        base = grant_log.size();
        issue(2, 1'b1, 32'hA0, 32'h0BAD_F00D, 4'h5);
        tick();
        issue(0, 1'b0, 32'hB0, 32'h0, 4'h0);
        issue(1, 1'b1, 32'hB4, 32'h1111_2222, 4'hC);
        issue(3, 1'b0, 32'hB8, 32'h0, 4'h0);
        wait_grants(base, 4, 80);
        ord[0] = 2; ord[1] = 3; ord[2] = 0; ord[3] = 1;
        for (int k = 0; k < 4; k++) begin
            if (grant_log.size() > base + k) chk("order_iso", grant_log[base + k], ord[k]);
        end
        drain(40);

        // Randomised traffic
        rand_en = 1'b1;
        repeat (1500) tick();
        rand_en = 1'b0;
        drain(200);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/taxi_apb_arb.md
Name: taxi_apb_arb

Overview:
- N-to-1 APB arbiter. PORTS upstream APB managers share one downstream APB completer bus.
- Selects one pending request (round-robin) and replays it downstream as a fresh SETUP/ACCESS pair. Captures the response and returns it to the granted manager.
- Sits between CPU/DMA/debug APB managers and a shared register-bank bus. Fully registered outputs.

Parameters:
- PORTS, 4, number of upstream ports (1..16).
- TIMEOUT_CYCLES, 1024, downstream ACCESS cycle limit; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- s_apb  taxi_apb_if.slv  array [PORTS]  upstream ports; each is a completer facing one manager.
- m_apb  taxi_apb_if.mst  1  downstream manager port.
- busy  output  1  transfer in progress (state != IDLE).
- gnt_idx  output  CL_PORTS  index of the current or last grant; CL_PORTS = max($clog2(PORTS),1).

Behaviour:
- Widths: DATA_W, ADDR_W and STRB_W are taken from m_apb. Every s_apb must match them; a mismatch is an elaboration error ($fatal).
- Reset (sync): state=IDLE; m_apb psel/penable/pwrite=0, paddr/pwdata/pstrb/pprot=0; all s_apb pready/pslverr=0, prdata=0; busy=0; gnt_idx=0; rr pointer=PORTS-1, so port 0 wins first. Reset mid-transfer abandons it immediately; downstream psel drops the next cycle; no upstream response is given.
- Request: s_apb[i].psel=1. penable is not required to grant.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any request, pick winner i = first requester strictly after rr pointer (wrapping). Latch paddr/pprot/pwrite/pwdata/pstrb of port i, set gnt_idx=i, rr pointer=i, go to SETUP. No request: stay.
- SETUP: m_apb psel=1, penable=0, latched fields driven. Next state ACCESS.
- ACCESS: psel=1, penable=1, fields held stable. On m_apb.pready=1: capture prdata/pslverr, drop psel/penable next cycle, go to RESP. Otherwise stay.
- RESP: s_apb[gnt_idx] pready=1 with captured prdata/pslverr for exactly one cycle; then IDLE.
- Non-granted ports always drive pready=0, prdata=0, pslverr=0.
- Latency: request sampled in IDLE cycle N -> m psel N+1, m penable N+2; with zero-wait completer, upstream pready at N+3. Each downstream wait state adds one cycle.
- The granted upstream manager is held in its ACCESS phase (penable=1, pready=0) until RESP; APB rules guarantee its fields stay stable.
- Back-to-back: after RESP the FSM passes through IDLE for one cycle, so the minimum upstream transfer is 4 cycles. A port requesting again immediately competes normally; round-robin prevents starvation.
- Upstream psel dropped while granted (protocol violation): transfer still completes downstream; the RESP pulse is still issued.
- PORTS=1: the pointer is a constant; the same FSM applies.

Optional Feature:
- Macro TAXI_APB_ARB_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. When it reaches TIMEOUT_CYCLES with no pready, drop m psel/penable and go to RESP with pslverr=1, prdata=0. The counter clears on entering ACCESS.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- taxi_apb_pkg: state enum typedef (IDLE/SETUP/ACCESS/RESP) and the CL_PORTS width helper function.
- Sub-module taxi_apb_arb_rr: combinational round-robin picker. Inputs req[PORTS] and pointer; outputs valid and index.
- FSM, field latches and the response mux live in taxi_apb_arb.

Test Plan:
- Single write: port 1 writes paddr=0x40, pwdata=0xDEADBEEF, pstrb=0xF; completer zero-wait -> m psel at N+1, penable at N+2, s_apb[1].pready at N+3, gnt_idx=1.
- Read with 3 wait states: port 0 reads 0x10; completer returns 0x12345678, pslverr=1 -> s_apb[0] sees prdata=0x12345678, pslverr=1, pready at N+6.
- Contention: ports 0,2,3 request together from reset -> grant order 0,2,3. Then all four request continuously -> order 0,1,2,3,0 repeating.
- Reset mid-ACCESS: rst at cycle N+2 -> m psel=0 at N+3, no upstream pready, next grant goes to port 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): completer never asserts pready -> upstream pready with pslverr=1, prdata=0 after 8 ACCESS cycles. Macro undefined -> still waiting at cycle 100.
- Isolation: during a port 2 transfer, ports 0/1/3 hold psel=1 -> their pready stays 0 throughout; m fields stay stable across SETUP/ACCESS.
